// File: rtl/joy_db15_pkg.sv
// Shared definitions for the DB15 serial joystick link (device model and master scanner).
// Holds the link state encoding, frame geometry and the button bit map.
package joy_db15_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOADING  = 2'd1,
    ST_SHIFTING = 2'd2,
    ST_DONE     = 2'd3
  } joy_state_e;

  localparam int FRAME_BITS = 32;
  localparam int WORD_BITS  = 16;

  // Button positions inside one 16-bit joystick word
  localparam int BIT_R  = 0;
  localparam int BIT_L  = 1;
  localparam int BIT_DN = 2;
  localparam int BIT_UP = 3;
  localparam int BIT_A  = 4;
  localparam int BIT_B  = 5;
  localparam int BIT_C  = 6;
  localparam int BIT_D  = 7;
  localparam int BIT_E  = 8;
  localparam int BIT_F  = 9;
  localparam int BIT_S  = 10;
  localparam int BIT_LT = 11;

  // Buttons are active-low on the wire; P1 occupies the low half so it goes out first
  function automatic logic [31:0] wire_word(input logic [15:0] j1, input logic [15:0] j2);
    return ~{j2, j1};
  endfunction

endpackage

// File: rtl/joy_db15_sync_filt.sv
// Two-flop synchronizer followed by a FILT-cycle stability filter for one async link pin.
// rise pulses for one clk cycle in the cycle the filtered level becomes 1.
module joy_db15_sync_filt #(
  parameter int   FILT    = 3,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam logic [2:0] CNT_MAX = 3'(FILT - 1);

  logic       meta_r;
  logic       sync_r;
  logic       level_r;
  logic       rise_r;
  logic [2:0] cnt_r;

  // Synchronize, then accept a new level only after FILT consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r  <= RST_VAL;
      sync_r  <= RST_VAL;
      level_r <= RST_VAL;
      rise_r  <= 1'b0;
      cnt_r   <= 3'd0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      rise_r <= 1'b0;
      if (sync_r == level_r) begin
        cnt_r <= 3'd0;
      end else if (cnt_r == CNT_MAX) begin
        level_r <= sync_r;
        rise_r  <= sync_r;
        cnt_r   <= 3'd0;
      end else begin
        cnt_r <= cnt_r + 3'd1;
      end
    end
  end

  assign level = level_r;
  assign rise  = rise_r;

endmodule

// File: rtl/joy_db15_tx.sv
// Device side of the DB15 joystick link: a 32-bit parallel-in/serial-out register
// loaded while JOY_LOAD is low and shifted one bit per filtered JOY_CLK rising edge.
module joy_db15_tx #(
  parameter int   FILT       = 3,
  parameter int   FRAME_BITS = 32,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  input  logic        JOY_CLK,
  input  logic        JOY_LOAD,
  output logic        JOY_DATA,
  output logic        frame_done,
  output logic        overrun,
  output logic [5:0]  bit_cnt
);

  import joy_db15_pkg::*;

  localparam logic [5:0] LAST_CNT = 6'(FRAME_BITS - 1);

  joy_state_e  state_r, state_nx_s;
  logic [31:0] sh_r, sh_nx_s;
  logic [5:0]  cnt_r, cnt_nx_s;
  logic        ovr_r, ovr_nx_s;
  logic        done_r, done_nx_s;
  logic        data_r, data_nx_s;
  logic        load_f_s, load_rise_s;
  logic        clk_f_s, clk_rise_s;
  logic        edge_s;

  joy_db15_sync_filt #(.FILT(FILT), .RST_VAL(1'b1)) u_clk_filt (
    .clk   (clk),
    .reset (reset),
    .din   (JOY_CLK),
    .level (clk_f_s),
    .rise  (clk_rise_s)
  );

  joy_db15_sync_filt #(.FILT(FILT), .RST_VAL(1'b1)) u_load_filt (
    .clk   (clk),
    .reset (reset),
    .din   (JOY_LOAD),
    .level (load_f_s),
    .rise  (load_rise_s)
  );

  assign edge_s = clk_rise_s & clk_f_s;

  // Next-state, shift register and flag logic; an active load overrides every state
  always_comb begin
    state_nx_s = state_r;
    sh_nx_s    = sh_r;
    cnt_nx_s   = cnt_r;
    ovr_nx_s   = ovr_r;
    done_nx_s  = 1'b0;
    if (!load_f_s) begin
      state_nx_s = ST_LOADING;
      sh_nx_s    = wire_word(joystick1, joystick2);
      cnt_nx_s   = 6'd0;
      ovr_nx_s   = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = ST_IDLE;
        end
        ST_LOADING: begin
          // load_f only returns high through a filtered rise, so this exits on the first high cycle
          if (load_rise_s) begin
            state_nx_s = ST_SHIFTING;
          end else begin
            state_nx_s = ST_LOADING;
          end
        end
        ST_SHIFTING: begin
          if (edge_s) begin
            sh_nx_s  = {1'b1, sh_r[31:1]};
            cnt_nx_s = cnt_r + 6'd1;
            if (cnt_r == LAST_CNT) begin
              state_nx_s = ST_DONE;
              done_nx_s  = 1'b1;
            end else begin
              state_nx_s = ST_SHIFTING;
            end
          end else begin
            state_nx_s = ST_SHIFTING;
          end
        end
        ST_DONE: begin
          if (edge_s) begin
            ovr_nx_s = 1'b1;
          end else begin
            ovr_nx_s = ovr_r;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // Wire level follows the next shift value only while a frame is loaded or shifting
  always_comb begin
    data_nx_s = IDLE_LEVEL;
    case (state_nx_s)
      ST_LOADING:  data_nx_s = sh_nx_s[0];
      ST_SHIFTING: data_nx_s = sh_nx_s[0];
      default:     data_nx_s = IDLE_LEVEL;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      sh_r    <= 32'hFFFF_FFFF;
      cnt_r   <= 6'd0;
      ovr_r   <= 1'b0;
      done_r  <= 1'b0;
      data_r  <= 1'b1;
    end else begin
      state_r <= state_nx_s;
      sh_r    <= sh_nx_s;
      cnt_r   <= cnt_nx_s;
      ovr_r   <= ovr_nx_s;
      done_r  <= done_nx_s;
      data_r  <= data_nx_s;
    end
  end

  assign JOY_DATA   = data_r;
  assign frame_done = done_r;
  assign overrun    = ovr_r;
  assign bit_cnt    = cnt_r;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx: frames, abort, glitch rejection, overrun and
// mid-frame input changes, with hand-computed wire streams.
module tb_joy_db15_tx;
  import joy_db15_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        JOY_CLK;
  logic        JOY_LOAD;
  logic        JOY_DATA;
  logic        frame_done;
  logic        overrun;
  logic [5:0]  bit_cnt;

  int          n_tests   = 0;
  int          n_fail    = 0;
  int          done_cnt  = 0;
  int          done_edge = 0;
  int          edge_idx  = 0;
  logic        b;
  logic [31:0] stream;

  always #5 clk = ~clk;

  joy_db15_tx #(.FILT(3), .FRAME_BITS(32), .IDLE_LEVEL(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .JOY_CLK    (JOY_CLK),
    .JOY_LOAD   (JOY_LOAD),
    .JOY_DATA   (JOY_DATA),
    .frame_done (frame_done),
    .overrun    (overrun),
    .bit_cnt    (bit_cnt)
  );

  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      done_cnt  = done_cnt + 1;
      done_edge = edge_idx;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_low();
    edge_idx = 0;
    JOY_LOAD = 1'b0;
    cycles(20);
  endtask

  task automatic load_release();
    JOY_LOAD = 1'b1;
    cycles(10);
  endtask

  // Master-style edge: sample JOY_DATA just before raising JOY_CLK
  task automatic jclk(output logic bit_o);
    bit_o    = JOY_DATA;
    JOY_CLK  = 1'b1;
    edge_idx = edge_idx + 1;
    cycles(20);
    JOY_CLK  = 1'b0;
    cycles(20);
  endtask

  initial begin
    reset     = 1'b1;
    JOY_CLK   = 1'b0;
    JOY_LOAD  = 1'b1;
    joystick1 = 16'h0000;
    joystick2 = 16'h0000;
    stream    = 32'h0;
    cycles(3);
    check("rst_data",    32'(JOY_DATA),    32'h1);
    check("rst_bitcnt",  32'(bit_cnt),     32'h0);
    check("rst_done",    32'(frame_done),  32'h0);
    check("rst_ovr",     32'(overrun),     32'h0);
    check("rst_state",   32'(dut.state_r), 32'(ST_IDLE));
    reset = 1'b0;
    cycles(10);
    check("idle_data",   32'(JOY_DATA),    32'h1);
    check("idle_state",  32'(dut.state_r), 32'(ST_IDLE));

    // Basic frame
    joystick1 = 16'h0001;
    joystick2 = 16'h8000;
    load_low();
    check("load_state",  32'(dut.state_r), 32'(ST_LOADING));
    check("load_data",   32'(JOY_DATA),    32'h0);
    check("load_bitcnt", 32'(bit_cnt),     32'h0);
    load_release();
    check("shift_state", 32'(dut.state_r), 32'(ST_SHIFTING));
    for (int i = 0; i < 32; i++) begin
      jclk(b);
      stream[i] = b;
    end
    check("basic_stream", stream,             32'h7FFF_FFFE);
    check("basic_ndone",  32'(done_cnt),      32'd1);
    check("basic_dedge",  32'(done_edge),     32'd32);
    check("basic_idle",   32'(JOY_DATA),      32'h1);
    check("basic_bitcnt", 32'(bit_cnt),       32'd32);
    check("basic_state",  32'(dut.state_r),   32'(ST_DONE));
    check("basic_ovr",    32'(overrun),       32'h0);

    // Overrun: 33 edges after one load
    joystick1 = 16'h1234;
    joystick2 = 16'hABCD;
    load_low();
    load_release();
    for (int i = 0; i < 32; i++) begin
      jclk(b);
      stream[i] = b;
    end
    check("ovr_stream",  stream,           32'h5432_EDCB);
    check("ovr_pre",     32'(overrun),     32'h0);
    jclk(b);
    check("ovr_set",     32'(overrun),     32'h1);
    check("ovr_ndone",   32'(done_cnt),    32'd2);
    check("ovr_dedge",   32'(done_edge),   32'd32);
    check("ovr_bitcnt",  32'(bit_cnt),     32'd32);
    load_low();
    check("ovr_clear",   32'(overrun),     32'h0);
    load_release();

    // Abort after 10 edges, then a fresh full frame
    joystick1 = 16'h00FF;
    joystick2 = 16'h0F0F;
    load_low();
    load_release();
    for (int i = 0; i < 10; i++) begin
      jclk(b);
      stream[i] = b;
    end
    check("abort_bits",   32'(stream[9:0]), 32'h300);
    check("abort_pre",    32'(bit_cnt),     32'd10);
    joystick1 = 16'h5A5A;
    joystick2 = 16'hC3C3;
    load_low();
    check("abort_bitcnt", 32'(bit_cnt),     32'd0);
    check("abort_state",  32'(dut.state_r), 32'(ST_LOADING));
    check("abort_ndone",  32'(done_cnt),    32'd2);
    load_release();
    for (int i = 0; i < 32; i++) begin
      jclk(b);
      stream[i] = b;
    end
    check("fresh_stream", stream,           32'h3C3C_A5A5);
    check("fresh_ndone",  32'(done_cnt),    32'd3);

    // Glitch rejection mid-frame
    joystick1 = 16'h0008;
    joystick2 = 16'h0000;
    load_low();
    load_release();
    for (int i = 0; i < 3; i++) begin
      jclk(b);
    end
    check("glt_pre_data", 32'(JOY_DATA),    32'h0);
    check("glt_pre_cnt",  32'(bit_cnt),     32'd3);
    JOY_LOAD = 1'b0;
    cycles(1);
    JOY_LOAD = 1'b1;
    cycles(5);
    JOY_CLK = 1'b1;
    cycles(2);
    JOY_CLK = 1'b0;
    cycles(15);
    check("glt_data",     32'(JOY_DATA),    32'h0);
    check("glt_bitcnt",   32'(bit_cnt),     32'd3);
    check("glt_state",    32'(dut.state_r), 32'(ST_SHIFTING));

    // Input change mid-frame does not reach the wire
    joystick1 = 16'h0000;
    joystick2 = 16'h0000;
    load_low();
    load_release();
    for (int i = 0; i < 5; i++) begin
      jclk(b);
      stream[i] = b;
    end
    joystick1 = 16'hFFFF;
    for (int i = 5; i < 32; i++) begin
      jclk(b);
      stream[i] = b;
    end
    check("chg_stream",   stream,           32'hFFFF_FFFF);
    check("chg_ndone",    32'(done_cnt),    32'd4);
    check("chg_bitcnt",   32'(bit_cnt),     32'd32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
